// File: rtl/qu_ic_scheduler.sv
// Collapsing-queue reservation station for INT/BRANCH/CONT uops feeding the single ALU; index equals age.
// Optional QU_IC_SCHED_BRANCH_PRIO_EN: select prefers the oldest ready BRANCH/CONT uop over older INT uops.
package qu_ic_pkg;
    localparam int PHY_RF_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        OPTYPE_INT    = 2'd0,
        OPTYPE_BRANCH = 2'd1,
        OPTYPE_CONT   = 2'd2
    } optype_e;

    typedef struct packed {
        optype_e                        optype;
        logic [3:0]                     func;
        logic                           rd_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rd;
        logic                           rs1_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs1;
        logic                           rs2_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs2;
        logic [15:0]                    imm;
    } uop_ic_t;

    localparam int UOP_WIDTH = $bits(uop_ic_t);
endpackage

module qu_ic_scheduler
    import qu_ic_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  dispatch_valid_in,
    output logic                                  dispatch_ready_out,
    input  logic [UOP_WIDTH-1:0]                  dispatch_uop_in,
    input  logic                                  dispatch_rs1_rdy_in,
    input  logic                                  dispatch_rs2_rdy_in,
    input  logic [WB_PORTS-1:0]                   wakeup_valid_in,
    input  logic [WB_PORTS*PHY_RF_ADDR_WIDTH-1:0] wakeup_tag_in,
    output logic                                  issue_valid_out,
    input  logic                                  issue_ready_in,
    output logic [UOP_WIDTH-1:0]                  issue_uop_out,
    input  logic                                  flush_in,
    output logic [$clog2(DEPTH+1)-1:0]            count_out
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = PHY_RF_ADDR_WIDTH;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
    uop_ic_t          uop_q [DEPTH];
    uop_ic_t          uop_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    uop_ic_t          disp_uop;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] pick_vec;
    logic [IW-1:0]    sel_idx;
    logic             sel_any;
    logic             issue_fire;
    logic             dispatch_fire;
    logic [CW-1:0]    tail;

    function automatic logic tag_hit(
        input logic                       src_valid,
        input logic [TW-1:0]              src_tag,
        input logic [WB_PORTS-1:0]        wk_vld,
        input logic [WB_PORTS*TW-1:0]     wk_tag
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wk_vld[k] && (wk_tag[k*TW +: TW] == src_tag)) begin
                hit = 1'b1;
            end
        end
        return src_valid && hit;
    endfunction

    assign disp_uop = uop_ic_t'(dispatch_uop_in);

    always_comb begin
        ready_vec = '0;
        pick_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i]
                         && (rs1_rdy_q[i] || !uop_q[i].rs1_valid)
                         && (rs2_rdy_q[i] || !uop_q[i].rs2_valid);
        end
`ifdef QU_IC_SCHED_BRANCH_PRIO_EN
        for (int i = 0; i < DEPTH; i++) begin
            pick_vec[i] = ready_vec[i] && ((uop_q[i].optype == OPTYPE_BRANCH)
                                        || (uop_q[i].optype == OPTYPE_CONT));
        end
        if (pick_vec == '0) begin
            pick_vec = ready_vec;
        end
`else
        pick_vec = ready_vec;
`endif
    end

    // Scan from the top so the lowest (oldest) candidate wins.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                sel_any = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    assign issue_valid_out    = sel_any && !flush_in;
    assign issue_uop_out      = issue_valid_out ? uop_q[sel_idx] : '0;
    assign dispatch_ready_out = (count_q < CW'(DEPTH)) && !flush_in;
    assign count_out          = count_q;
    assign issue_fire         = issue_valid_out && issue_ready_in;
    assign dispatch_fire      = dispatch_valid_in && dispatch_ready_out;

    always_comb begin
        tail = count_q - CW'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && (IW'(i) >= sel_idx)) begin
                valid_d[i]   = (i != DEPTH-1) && valid_q[(i+1)%DEPTH];
                uop_d[i]     = uop_q[(i+1)%DEPTH];
                rs1_rdy_d[i] = rs1_rdy_q[(i+1)%DEPTH];
                rs2_rdy_d[i] = rs2_rdy_q[(i+1)%DEPTH];
            end else begin
                valid_d[i]   = valid_q[i];
                uop_d[i]     = uop_q[i];
                rs1_rdy_d[i] = rs1_rdy_q[i];
                rs2_rdy_d[i] = rs2_rdy_q[i];
            end
            rs1_rdy_d[i] = rs1_rdy_d[i] | (valid_d[i] && tag_hit(uop_d[i].rs1_valid,
                               uop_d[i].rs1, wakeup_valid_in, wakeup_tag_in));
            rs2_rdy_d[i] = rs2_rdy_d[i] | (valid_d[i] && tag_hit(uop_d[i].rs2_valid,
                               uop_d[i].rs2, wakeup_valid_in, wakeup_tag_in));
            // Tail write sees the post-shift position, so it never collides with a live entry.
            if (dispatch_fire && (CW'(i) == tail)) begin
                valid_d[i]   = 1'b1;
                uop_d[i]     = disp_uop;
                rs1_rdy_d[i] = dispatch_rs1_rdy_in | tag_hit(disp_uop.rs1_valid,
                                   disp_uop.rs1, wakeup_valid_in, wakeup_tag_in);
                rs2_rdy_d[i] = dispatch_rs2_rdy_in | tag_hit(disp_uop.rs2_valid,
                                   disp_uop.rs2, wakeup_valid_in, wakeup_tag_in);
            end
        end
        if (flush_in) begin
            valid_d = '0;
        end
    end

    always_comb begin
        if (flush_in) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(dispatch_fire) - CW'(issue_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                uop_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            count_q   <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                uop_q[i] <= uop_d[i];
            end
        end
    end
endmodule

// File: tb/tb_qu_ic_scheduler.sv
// Directed bench for qu_ic_scheduler: per-cycle vector table plus fill/drain and async-reset sequences.
module tb_qu_ic_scheduler;
    import qu_ic_pkg::*;

    localparam int DEPTH = 8;
    localparam int WB    = 2;
    localparam int TW    = PHY_RF_ADDR_WIDTH;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int UW    = UOP_WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              d_vld;
    logic              d_rdy;
    uop_ic_t           d_uop;
    logic              d_r1;
    logic              d_r2;
    logic [WB-1:0]     wk_vld;
    logic [WB*TW-1:0]  wk_tag;
    logic              iss_vld;
    logic              iss_rdy;
    logic [UW-1:0]     iss_uop;
    logic              flush;
    logic [CW-1:0]     cnt;

    qu_ic_scheduler #(.DEPTH(DEPTH), .WB_PORTS(WB)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dispatch_valid_in   (d_vld),
        .dispatch_ready_out  (d_rdy),
        .dispatch_uop_in     (d_uop),
        .dispatch_rs1_rdy_in (d_r1),
        .dispatch_rs2_rdy_in (d_r2),
        .wakeup_valid_in     (wk_vld),
        .wakeup_tag_in       (wk_tag),
        .issue_valid_out     (iss_vld),
        .issue_ready_in      (iss_rdy),
        .issue_uop_out       (iss_uop),
        .flush_in            (flush),
        .count_out           (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dv;
        uop_ic_t       u;
        logic          r1;
        logic          r2;
        logic [1:0]    wv;
        logic [TW-1:0] t0;
        logic [TW-1:0] t1;
        logic          ir;
        logic          fl;
        logic          e_drdy;
        logic          e_iv;
        uop_ic_t       e_u;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic uop_ic_t mk(input optype_e t, input logic [5:0] rd,
                                   input logic r1v, input logic [5:0] r1,
                                   input logic r2v, input logic [5:0] r2);
        uop_ic_t u;
        u           = '0;
        u.optype    = t;
        u.rd_valid  = 1'b1;
        u.rd        = rd;
        u.rs1_valid = r1v;
        u.rs1       = r1;
        u.rs2_valid = r2v;
        u.rs2       = r2;
        u.imm       = {10'h0, rd};
        return u;
    endfunction

    function automatic vec_t V(input logic dv, input uop_ic_t u, input logic r1, input logic r2,
                               input logic [1:0] wv, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                               input logic ir, input logic fl,
                               input logic e_drdy, input logic e_iv, input uop_ic_t e_u,
                               input logic [CW-1:0] e_cnt);
        vec_t v;
        v.dv = dv; v.u = u; v.r1 = r1; v.r2 = r2; v.wv = wv; v.t0 = t0; v.t1 = t1;
        v.ir = ir; v.fl = fl; v.e_drdy = e_drdy; v.e_iv = e_iv; v.e_u = e_u; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input uop_ic_t u, input logic r1, input logic r2,
                         input logic [1:0] wv, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                         input logic ir, input logic fl);
        d_vld   = dv;
        d_uop   = u;
        d_r1    = r1;
        d_r2    = r2;
        wk_vld  = wv;
        wk_tag  = {t1, t0};
        iss_rdy = ir;
        flush   = fl;
    endtask

    task automatic expect_out(input string tag, input logic e_drdy, input logic e_iv,
                              input uop_ic_t e_u, input logic [CW-1:0] e_cnt);
        chk({tag, " dispatch_ready"}, UW'(d_rdy), UW'(e_drdy));
        chk({tag, " issue_valid"},    UW'(iss_vld), UW'(e_iv));
        chk({tag, " issue_uop"},      iss_uop, e_u);
        chk({tag, " count"},          UW'(cnt), UW'(e_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        uop_ic_t Z, U1, A, B, C, D, I0, X, BR, P1, P2, FX;
        uop_ic_t E [5];
        uop_ic_t F [8];

        Z  = '0;
        U1 = mk(OPTYPE_INT, 6'd1, 1'b1, 6'd5, 1'b0, 6'd0);
        A  = mk(OPTYPE_INT, 6'd2, 1'b1, 6'd7, 1'b0, 6'd0);
        B  = mk(OPTYPE_INT, 6'd3, 1'b0, 6'd0, 1'b0, 6'd0);
        C  = mk(OPTYPE_INT, 6'd4, 1'b0, 6'd0, 1'b1, 6'd9);
        D  = mk(OPTYPE_INT, 6'd5, 1'b1, 6'd10, 1'b0, 6'd0);
        for (int k = 0; k < 5; k++) E[k] = mk(OPTYPE_INT, 6'(10 + k), 1'b0, 6'd0, 1'b0, 6'd0);
        for (int k = 0; k < 8; k++) F[k] = mk(OPTYPE_INT, 6'(40 + k), 1'b0, 6'd0, 1'b0, 6'd0);
        FX = mk(OPTYPE_INT, 6'd50, 1'b0, 6'd0, 1'b0, 6'd0);
        I0 = mk(OPTYPE_INT, 6'd20, 1'b0, 6'd0, 1'b0, 6'd0);
        X  = mk(OPTYPE_INT, 6'd21, 1'b1, 6'd30, 1'b0, 6'd0);
        BR = mk(OPTYPE_BRANCH, 6'd22, 1'b0, 6'd0, 1'b0, 6'd0);
`ifdef QU_IC_SCHED_BRANCH_PRIO_EN
        P1 = BR;
        P2 = I0;
`else
        P1 = I0;
        P2 = BR;
`endif

        // idle after reset
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 0, 0,   1, 0, Z, 0));
        // single ready uop: 0 -> 1 -> 0
        vt.push_back(V(1, U1, 1, 0, 2'b00, 0, 0, 1, 0,  1, 0, Z, 0));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, U1, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        // younger ready B overtakes A, A woken by tag 7
        vt.push_back(V(1, A, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        vt.push_back(V(1, B, 1, 1, 2'b00, 0, 0, 1, 0,   1, 0, Z, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, B, 2));
        vt.push_back(V(0, Z, 0, 0, 2'b01, 7, 0, 1, 0,   1, 0, Z, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, A, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        // same-cycle bypass on port 1
        vt.push_back(V(1, C, 1, 0, 2'b10, 0, 9, 1, 0,   1, 0, Z, 0));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, C, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        // wrong tag and invalid port must not wake
        vt.push_back(V(1, D, 0, 1, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        vt.push_back(V(0, Z, 0, 0, 2'b01, 11, 0, 1, 0,  1, 0, Z, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b01, 0, 10, 1, 0,  1, 0, Z, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b10, 0, 10, 1, 0,  1, 0, Z, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, D, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        // four entries then flush with a dispatch offered
        vt.push_back(V(1, E[0], 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, Z, 0));
        vt.push_back(V(1, E[1], 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, E[0], 1));
        vt.push_back(V(1, E[2], 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, E[0], 2));
        vt.push_back(V(1, E[3], 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, E[0], 3));
        vt.push_back(V(1, E[4], 0, 0, 2'b00, 0, 0, 1, 1, 0, 0, Z, 4));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));
        // INT at 0, blocked X at 1, BRANCH at 2
        vt.push_back(V(1, I0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 0, Z, 0));
        vt.push_back(V(1, X, 0, 0, 2'b00, 0, 0, 0, 0,   1, 1, I0, 1));
        vt.push_back(V(1, BR, 0, 0, 2'b00, 0, 0, 0, 0,  1, 1, I0, 2));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, P1, 3));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, P2, 2));
        vt.push_back(V(0, Z, 0, 0, 2'b01, 30, 0, 1, 0,  1, 0, Z, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 1, X, 1));
        vt.push_back(V(0, Z, 0, 0, 2'b00, 0, 0, 1, 0,   1, 0, Z, 0));

        rst = 1'b1;
        drive(0, Z, 0, 0, 2'b00, 0, 0, 0, 0);
        #8;
        expect_out("reset", 1, 0, Z, 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].dv, vt[i].u, vt[i].r1, vt[i].r2, vt[i].wv, vt[i].t0, vt[i].t1,
                  vt[i].ir, vt[i].fl);
            @(negedge clk);
            expect_out($sformatf("v%0d", i), vt[i].e_drdy, vt[i].e_iv, vt[i].e_u, vt[i].e_cnt);
            @(posedge clk); #1;
        end

        // fill to DEPTH with issue held off
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, F[i], 1, 1, 2'b00, 0, 0, 0, 0);
            @(negedge clk);
            expect_out($sformatf("fill%0d", i), 1, (i > 0), (i > 0) ? F[0] : Z, CW'(i));
            @(posedge clk); #1;
        end
        drive(1, FX, 1, 1, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("full", 0, 1, F[0], CW'(DEPTH));
        @(posedge clk); #1;

        // drain in order; dispatch offered in the first full+issue cycle is refused
        for (int i = 0; i < DEPTH; i++) begin
            drive((i == 0), FX, 1, 1, 2'b00, 0, 0, 1, 0);
            @(negedge clk);
            expect_out($sformatf("drain%0d", i), (i != 0), 1, F[i], CW'(DEPTH - i));
            @(posedge clk); #1;
        end
        drive(0, Z, 0, 0, 2'b00, 0, 0, 1, 0);
        @(negedge clk);
        expect_out("drained", 1, 0, Z, 0);
        @(posedge clk); #1;

        // asynchronous reset with entries present
        drive(1, F[0], 1, 1, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, F[1], 1, 1, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, Z, 0, 0, 2'b00, 0, 0, 1, 0);
        @(negedge clk);
        expect_out("pre_rst", 1, 1, F[0], 2);
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 1, 0, Z, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        expect_out("post_rst", 1, 0, Z, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
